// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encodings and bus field widths.
package i2c_pkg;

    localparam int unsigned I2C_ADDR_LEN = 7;
    localparam int unsigned I2C_BITS     = 8;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADDR     = 3'd1,
        S_ADDR_ACK = 3'd2,
        S_RX       = 3'd3,
        S_RX_ACK   = 3'd4,
        S_TX       = 3'd5,
        S_TX_ACK   = 3'd6
    } i2c_state_e;

endpackage

// File: rtl/i2c_bus_sync.sv
// I2C bus front end: SCL/SDA synchronizers, SCL edge detect, START/STOP detect.
module i2c_bus_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    // [1:0] form the 2-FF synchronizer, [2] is the previous synchronized value
    logic [2:0] scl_q;
    logic [2:0] sda_q;

    // Synchronize both lines; preset to the idle (released) bus level
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scl_q <= '1;
            sda_q <= '1;
        end else begin
            scl_q <= {scl_q[1:0], scl_i};
            sda_q <= {sda_q[1:0], sda_i};
        end
    end

    assign sda_o      = sda_q[1];
    assign scl_rise_o = scl_q[1] & ~scl_q[2];
    assign scl_fall_o = ~scl_q[1] & scl_q[2];
    // SCL must be high on both samples so an SDA change coincident with an SCL edge is ignored
    assign start_o    = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
    assign stop_o     = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];

endmodule

// File: rtl/i2c_slave.sv
// I2C target: 7-bit addressed, ACKs every written byte, streams DataToMaster on reads.
module i2c_slave
    import i2c_pkg::*;
#(
    parameter int unsigned               ADDRESSLENGTH = I2C_ADDR_LEN,
    parameter logic [ADDRESSLENGTH-1:0]  SLAVE_ADDRESS = 7'h50
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SCL,
    inout  wire        SDA,
    input  logic [7:0] DataToMaster,
    output logic [7:0] DataFromMaster,
    output logic       RxValid,
    output logic       TxLoad,
    output logic       RorW,
    output logic       Busy,
    output logic [2:0] state
);

    localparam logic [3:0] ADDR_BITS = 4'(ADDRESSLENGTH + 1);
    localparam logic [3:0] BYTE_BITS = 4'(I2C_BITS);

    logic sda_s, scl_rise, scl_fall, start_det, stop_det;

    i2c_bus_sync u_sync (
        .clk_i      (CLK),
        .rst_ni     (RST),
        .scl_i      (SCL),
        .sda_i      (SDA),
        .sda_o      (sda_s),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (start_det),
        .stop_o     (stop_det)
    );

    i2c_state_e             state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [ADDRESSLENGTH:0] addr_q, addr_d;
    logic [6:0]             shift_q, shift_d;
    logic [6:0]             tx_q, tx_d;
    logic [7:0]             data_q, data_d;
    logic                   rxvalid_q, rxvalid_d;
    logic                   txload_q, txload_d;
    logic                   rorw_q, rorw_d;
    logic                   busy_q, busy_d;
    logic                   sda_oe_q, sda_oe_d;
    logic                   addr_match;

    assign addr_match = (addr_q[ADDRESSLENGTH:1] == SLAVE_ADDRESS);

    // State and datapath registers; reset releases SDA asynchronously
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            shift_q   <= '0;
            tx_q      <= '0;
            data_q    <= '0;
            rxvalid_q <= 1'b0;
            txload_q  <= 1'b0;
            rorw_q    <= 1'b0;
            busy_q    <= 1'b0;
            sda_oe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            data_q    <= data_d;
            rxvalid_q <= rxvalid_d;
            txload_q  <= txload_d;
            rorw_q    <= rorw_d;
            busy_q    <= busy_d;
            sda_oe_q  <= sda_oe_d;
        end
    end

    // Next-state: START/STOP override everything, otherwise advance on SCL edges
    always_comb begin
        state_d = state_q;
        if (stop_det) begin
            state_d = S_IDLE;
        end else if (start_det) begin
            state_d = S_ADDR;
        end else begin
            case (state_q)
                S_ADDR:     if (scl_fall && cnt_q == ADDR_BITS) state_d = addr_match ? S_ADDR_ACK : S_IDLE;
                S_ADDR_ACK: if (scl_fall) state_d = rorw_q ? S_TX : S_RX;
                S_RX:       if (scl_fall && cnt_q == BYTE_BITS) state_d = S_RX_ACK;
                S_RX_ACK:   if (scl_fall) state_d = S_RX;
                S_TX:       if (scl_fall && cnt_q == BYTE_BITS - 4'd1) state_d = S_TX_ACK;
                // cnt_q==1 records that the master ACKed on the preceding rise
                S_TX_ACK: begin
                    if (scl_rise && sda_s)            state_d = S_IDLE;
                    else if (scl_fall && cnt_q == 4'd1) state_d = S_TX;
                end
                default:    state_d = S_IDLE;
            endcase
        end
    end

    // Datapath and outputs: shifters, bit counter, SDA drive, strobes
    always_comb begin
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        data_d    = data_q;
        rxvalid_d = 1'b0;
        txload_d  = 1'b0;
        rorw_d    = rorw_q;
        busy_d    = busy_q;
        sda_oe_d  = sda_oe_q;
        if (stop_det) begin
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start_det) begin
            sda_oe_d = 1'b0;
        end else begin
            case (state_q)
                S_ADDR: begin
                    if (scl_rise && cnt_q < ADDR_BITS) begin
                        addr_d = {addr_q[ADDRESSLENGTH-1:0], sda_s};
                        cnt_d  = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q == ADDR_BITS) begin
                        sda_oe_d = addr_match;
                        busy_d   = addr_match;
                        if (addr_match) rorw_d = addr_q[0];
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = rorw_q ? ~DataToMaster[7] : 1'b0;
                        if (rorw_q) begin
                            tx_d     = DataToMaster[6:0];
                            txload_d = 1'b1;
                        end
                    end
                end
                S_RX: begin
                    if (scl_rise && cnt_q < BYTE_BITS) begin
                        shift_d = {shift_q[5:0], sda_s};
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == BYTE_BITS - 4'd1) begin
                            data_d    = {shift_q, sda_s};
                            rxvalid_d = 1'b1;
                        end
                    end else if (scl_fall && cnt_q == BYTE_BITS) begin
                        sda_oe_d = 1'b1;
                    end
                end
                S_RX_ACK: if (scl_fall) sda_oe_d = 1'b0;
                // tx_q holds the bits still to send after the one currently on SDA
                S_TX: begin
                    if (scl_fall) begin
                        if (cnt_q == BYTE_BITS - 4'd1) begin
                            sda_oe_d = 1'b0;
                        end else begin
                            sda_oe_d = ~tx_q[6];
                            tx_d     = {tx_q[5:0], 1'b0};
                            cnt_d    = cnt_q + 4'd1;
                        end
                    end
                end
                S_TX_ACK: begin
                    if (scl_rise) begin
                        if (sda_s) busy_d = 1'b0;
                        else       cnt_d  = 4'd1;
                    end else if (scl_fall && cnt_q == 4'd1) begin
                        sda_oe_d = ~DataToMaster[7];
                        tx_d     = DataToMaster[6:0];
                        txload_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        if (state_d != state_q) cnt_d = '0;
    end

    assign SDA            = sda_oe_q ? 1'b0 : 1'bz;
    assign DataFromMaster = data_q;
    assign RxValid        = rxvalid_q;
    assign TxLoad         = txload_q;
    assign RorW           = rorw_q;
    assign Busy           = busy_q;
    assign state          = state_q;

endmodule
